// File: rtl/hdlc_rx_deframer.sv
// ============================================================================
// Module   : hdlc_rx_deframer
// Purpose  : Receive-side HDLC deframer. Samples the serial Rx line, hunts for
//            flags, deletes stuffed zeros, detects aborts and delivers
//            LSB-first data bytes plus per-frame status strobes to the Rx
//            buffer/register logic.
// Ports    :
//   i_clk               system clock, rising edge
//   i_rst_n             asynchronous, active-low reset
//   i_rx                serial line, one bit per enabled sample
//   i_rx_en             sample enable; 0 = all state holds
//   o_rx_data[7:0]      assembled byte, first-received bit = bit 0
//   o_rx_valid          one-cycle strobe, o_rx_data valid
//   o_rx_flag_detect    one-cycle strobe per flag seen
//   o_rx_abort_detect   one-cycle strobe, frame aborted
//   o_rx_valid_frame    level, data bits received in current frame
//   o_rx_eof            one-cycle strobe, good frame closed
//   o_rx_frame_error    one-cycle strobe, misaligned close or overflow
//   o_rx_byte_count     bytes delivered in current/last frame
// Params   :
//   MAX_BYTES           max data bytes per frame (FCS included), 1..255
// Revision : 1.0 - initial release
// ============================================================================

`default_nettype none

module hdlc_rx_deframer #(
  parameter int MAX_BYTES = 128
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_rx_en,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_flag_detect,
  output logic       o_rx_abort_detect,
  output logic       o_rx_valid_frame,
  output logic       o_rx_eof,
  output logic       o_rx_frame_error,
  output logic [7:0] o_rx_byte_count
);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_frame = 1'b1;

  localparam logic [7:0] c_flag      = 8'h7E;
  localparam logic [7:0] c_max_bytes = 8'(MAX_BYTES);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0] r_state;
  logic [7:0] r_win;          // last 8 samples, r_win[7] is the oldest (exit bit)
  logic [7:0] r_mask;         // r_mask[i] = r_win[i] was sampled inside a frame
  logic [7:0] r_byte;         // byte under assembly, shifts in from the top
  logic [2:0] r_bit_cnt;
  logic [2:0] r_ones;         // run of accepted ones, for zero deletion
  logic [7:0] r_bytes;        // bytes delivered in the open frame

  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_flag_det;
  logic       r_abort_det;
  logic       r_valid_frame;
  logic       r_eof;
  logic       r_frame_err;
  logic [7:0] r_byte_count;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [7:0] w_win_n;
  logic       w_flag;
  logic       w_abort;
  logic       w_in_frame;

  logic       w_stage_en;
  logic       w_stage_bit;
  logic [7:0] w_byte_n;
  logic [2:0] w_bit_n;
  logic [2:0] w_ones_n;
  logic [7:0] w_bytes_p;      // byte counter after bit processing
  logic [7:0] w_bytes_n;      // byte counter after flag/abort handling
  logic [7:0] w_data_n;
  logic       w_done;
  logic       w_ovf;
  logic       w_accept;

  logic [0:0] w_state_n;
  logic [7:0] w_mask_n;
  logic       w_vf_n;
  logic       w_eof;
  logic       w_err;
  logic       w_abt;

  assign w_win_n    = {r_win[6:0], i_rx};
  assign w_flag     = (w_win_n == c_flag);
  // A flag has a zero in bit 0, so flag and abort are mutually exclusive.
  assign w_abort    = (w_win_n[6:0] == 7'h7F);
  assign w_in_frame = (r_state == c_st_frame);

  always_comb begin
    w_stage_en  = 1'b0;
    w_stage_bit = 1'b0;
    w_byte_n    = r_byte;
    w_bit_n     = r_bit_cnt;
    w_ones_n    = r_ones;
    w_bytes_p   = r_bytes;
    w_data_n    = r_rx_data;
    w_done      = 1'b0;
    w_ovf       = 1'b0;
    w_accept    = 1'b0;

    // Stage 0 processes the normal exit bit. Stage 1 runs only on an abort:
    // the bit just ahead of the seven ones (r_win[6]) is still real data and
    // would otherwise be lost with the window flush, so it is drained here.
    // This lets a byte whose last bit immediately precedes the abort still
    // be delivered. At most one of the two stages can complete a byte.
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        w_stage_en  = r_mask[7];
        w_stage_bit = r_win[7];
      end else begin
        w_stage_en  = w_abort && r_mask[6];
        w_stage_bit = r_win[6];
      end

      if (w_stage_en) begin
        if (!w_stage_bit && (w_ones_n == 3'd5)) begin
          // Stuffed zero after five ones: drop it.
          w_ones_n = 3'd0;
        end else begin
          w_accept = 1'b1;
          w_byte_n = {w_stage_bit, w_byte_n[7:1]};
          w_ones_n = w_stage_bit ? (w_ones_n + 3'd1) : 3'd0;
          if (w_bit_n == 3'd7) begin
            if (w_bytes_p < c_max_bytes) begin
              w_done    = 1'b1;
              w_data_n  = w_byte_n;
              w_bytes_p = w_bytes_p + 8'd1;
            end else begin
              w_ovf = 1'b1;
            end
          end
          w_bit_n = w_bit_n + 3'd1;
        end
      end
    end

    // Default: shift in the in-frame qualifier for the newest sample.
    w_state_n = r_state;
    w_mask_n  = {r_mask[6:0], w_in_frame};
    w_vf_n    = r_valid_frame | w_accept;
    w_bytes_n = w_bytes_p;
    w_eof     = 1'b0;
    w_err     = w_ovf;
    w_abt     = 1'b0;

    // Overflow: the completed byte is not delivered and the frame is dropped.
    if (w_ovf) begin
      w_state_n = c_st_idle;
      w_mask_n  = 8'd0;
      w_bit_n   = 3'd0;
      w_ones_n  = 3'd0;
      w_vf_n    = 1'b0;
    end

    if (w_flag) begin
      // Close evaluation sees the counters after this sample's exit bit, so
      // a byte finishing on the flag sample is counted before the decision.
      // An overflow on the same sample already reported the error.
      if (w_in_frame && !w_ovf) begin
        if (w_bit_n != 3'd0) begin
          w_err = 1'b1;
        end else if (w_bytes_p != 8'd0) begin
          w_eof = 1'b1;
        end
      end
      // The closing flag also opens the next frame (shared flags).
      w_state_n = c_st_frame;
      w_mask_n  = 8'd0;
      w_bit_n   = 3'd0;
      w_ones_n  = 3'd0;
      w_bytes_n = 8'd0;
      w_vf_n    = 1'b0;
    end else if (w_abort) begin
      // Only the first abort inside a frame reports; continued ones land in
      // IDLE and stay silent.
      w_abt     = w_in_frame;
      w_state_n = c_st_idle;
      w_mask_n  = 8'd0;
      w_bit_n   = 3'd0;
      w_ones_n  = 3'd0;
      w_bytes_n = 8'd0;
      w_vf_n    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= c_st_idle;
      r_win         <= 8'd0;
      r_mask        <= 8'd0;
      r_byte        <= 8'd0;
      r_bit_cnt     <= 3'd0;
      r_ones        <= 3'd0;
      r_bytes       <= 8'd0;
      r_rx_data     <= 8'd0;
      r_rx_valid    <= 1'b0;
      r_flag_det    <= 1'b0;
      r_abort_det   <= 1'b0;
      r_valid_frame <= 1'b0;
      r_eof         <= 1'b0;
      r_frame_err   <= 1'b0;
      r_byte_count  <= 8'd0;
    end else begin
      // Strobes last exactly one cycle, even when the enable drops.
      r_rx_valid  <= 1'b0;
      r_flag_det  <= 1'b0;
      r_abort_det <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_err <= 1'b0;

      if (i_rx_en) begin
        r_state       <= w_state_n;
        r_win         <= w_win_n;
        r_mask        <= w_mask_n;
        r_byte        <= w_byte_n;
        r_bit_cnt     <= w_bit_n;
        r_ones        <= w_ones_n;
        r_bytes       <= w_bytes_n;
        r_valid_frame <= w_vf_n;
        r_rx_data     <= w_data_n;
        r_rx_valid    <= w_done;
        r_flag_det    <= w_flag;
        r_abort_det   <= w_abt;
        r_eof         <= w_eof;
        r_frame_err   <= w_err;
        // The visible count holds its final value across the close and
        // restarts at 1 with the next frame's first byte.
        if (w_done) begin
          r_byte_count <= w_bytes_p;
        end
      end
    end
  end

  assign o_rx_data         = r_rx_data;
  assign o_rx_valid        = r_rx_valid;
  assign o_rx_flag_detect  = r_flag_det;
  assign o_rx_abort_detect = r_abort_det;
  assign o_rx_valid_frame  = r_valid_frame;
  assign o_rx_eof          = r_eof;
  assign o_rx_frame_error  = r_frame_err;
  assign o_rx_byte_count   = r_byte_count;

endmodule

`default_nettype wire

// File: tb/tb_hdlc_rx_deframer.sv
// ============================================================================
// Module   : tb_hdlc_rx_deframer
// Purpose  : Self-checking bench for hdlc_rx_deframer. A bit-stuffing
//            transmitter model drives the line; expected bytes are queued as
//            they are sent and popped when the DUT strobes o_rx_valid.
// Revision : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_hdlc_rx_deframer;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_en;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rx_flag_detect;
  logic       o_rx_abort_detect;
  logic       o_rx_valid_frame;
  logic       o_rx_eof;
  logic       o_rx_frame_error;
  logic [7:0] o_rx_byte_count;

  hdlc_rx_deframer #(.MAX_BYTES(MAXB)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_rx              (rx),
    .i_rx_en           (rx_en),
    .o_rx_data         (o_rx_data),
    .o_rx_valid        (o_rx_valid),
    .o_rx_flag_detect  (o_rx_flag_detect),
    .o_rx_abort_detect (o_rx_abort_detect),
    .o_rx_valid_frame  (o_rx_valid_frame),
    .o_rx_eof          (o_rx_eof),
    .o_rx_frame_error  (o_rx_frame_error),
    .o_rx_byte_count   (o_rx_byte_count)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_exp;
  int         n_valid, n_flag, n_abort, n_eof, n_err;
  bit         vf_seen;
  bit         gate_mode = 1'b0;
  int         tx_ones   = 0;

  // Scoreboard / strobe monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (o_rx_valid) begin
      n_valid++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rx_data unexpected: got %02h, required no byte", o_rx_data);
      end else begin
        m_exp = exp_q.pop_front();
        if (o_rx_data !== m_exp) begin
          bad++;
          $display("FAIL rx_data: got %02h, required %02h", o_rx_data, m_exp);
        end
      end
    end
    if (o_rx_flag_detect)  n_flag++;
    if (o_rx_abort_detect) n_abort++;
    if (o_rx_eof)          n_eof++;
    if (o_rx_frame_error)  n_err++;
    if (o_rx_valid_frame)  vf_seen = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Line drivers
  // --------------------------------------------------------------------------
  task automatic send_bit(input logic b);
    if (gate_mode) begin
      rx_en = 1'b0;
      rx    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rx    = b;
    rx_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 5) begin
      send_bit(1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit push);
    if (push) exp_q.push_back(d);
    for (int i = 0; i < 8; i++) send_data_bit(d[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    tx_ones = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_flag = 0; n_abort = 0; n_eof = 0; n_err = 0;
    vf_seen = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; rx_en = 1'b1;
    #1;
    total++;
    if ({o_rx_data, o_rx_byte_count} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data_count: got %04h, required 0000", {o_rx_data, o_rx_byte_count});
    end
    total++;
    if ({o_rx_valid, o_rx_flag_detect, o_rx_abort_detect, o_rx_valid_frame,
         o_rx_eof, o_rx_frame_error} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %06b, required 000000",
               {o_rx_valid, o_rx_flag_detect, o_rx_abort_detect, o_rx_valid_frame,
                o_rx_eof, o_rx_frame_error});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_rx_valid, o_rx_abort_detect, o_rx_valid_frame, o_rx_byte_count} !== 11'b0) begin
      bad++;
      $display("FAIL reset_held: got %011b, required 0", {o_rx_valid, o_rx_abort_detect,
               o_rx_valid_frame, o_rx_byte_count});
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_good_frame();
    clear_counts();
    repeat (3) send_flag();
    send_flag();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_flag();
    idle(1);
    total++;
    if (n_eof !== 1) begin bad++; $display("FAIL good_eof: got %0d, required 1", n_eof); end
    total++;
    if (n_flag !== 5) begin bad++; $display("FAIL good_flags: got %0d, required 5", n_flag); end
    total++;
    if (n_err !== 0) begin bad++; $display("FAIL good_err: got %0d, required 0", n_err); end
    total++;
    if (o_rx_byte_count !== 8'd2) begin
      bad++; $display("FAIL good_count: got %0d, required 2", o_rx_byte_count);
    end
    total++;
    if (vf_seen !== 1'b1 || o_rx_valid_frame !== 1'b0) begin
      bad++; $display("FAIL good_validframe: seen %0b now %0b, required 1 then 0",
                      vf_seen, o_rx_valid_frame);
    end
    total++;
    if (n_valid !== 2 || exp_q.size() !== 0) begin
      bad++; $display("FAIL good_bytes: got %0d left %0d, required 2 left 0", n_valid, exp_q.size());
    end
  endtask

  task automatic test_latency();
    logic [7:0] d;
    clear_counts();
    d = 8'h81;
    send_flag();
    send_byte(d, 1'b1);
    exp_q.push_back(8'h00);
    for (int j = 1; j <= 8; j++) begin
      send_data_bit(1'b0);
      if (j == 7) begin
        total++;
        if (o_rx_valid !== 1'b0) begin
          bad++; $display("FAIL latency_early: got %0b, required 0", o_rx_valid);
        end
      end
      if (j == 8) begin
        total++;
        if (o_rx_valid !== 1'b1) begin
          bad++; $display("FAIL latency_k8: got %0b, required 1", o_rx_valid);
        end
      end
    end
    send_flag();
    idle(1);
    total++;
    if (n_eof !== 1 || o_rx_byte_count !== 8'd2) begin
      bad++; $display("FAIL latency_close: eof %0d count %0d, required 1 and 2", n_eof, o_rx_byte_count);
    end
  endtask

  task automatic test_zero_deletion();
    clear_counts();
    send_flag();
    send_byte(8'hFF, 1'b1);
    send_byte(8'h7E, 1'b1);
    send_flag();
    idle(1);
    total++;
    if (n_flag !== 2 || n_abort !== 0) begin
      bad++; $display("FAIL zdel_strobes: flags %0d aborts %0d, required 2 and 0", n_flag, n_abort);
    end
    total++;
    if (n_eof !== 1 || n_valid !== 2) begin
      bad++; $display("FAIL zdel_close: eof %0d valid %0d, required 1 and 2", n_eof, n_valid);
    end
  endtask

  task automatic test_abort();
    clear_counts();
    send_flag();
    send_byte(8'h12, 1'b1);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    idle(1);
    total++;
    if (n_abort !== 1) begin bad++; $display("FAIL abort_count: got %0d, required 1", n_abort); end
    total++;
    if (n_eof !== 0 || n_valid !== 1) begin
      bad++; $display("FAIL abort_data: eof %0d valid %0d, required 0 and 1", n_eof, n_valid);
    end
    total++;
    if (vf_seen !== 1'b1 || o_rx_valid_frame !== 1'b0) begin
      bad++; $display("FAIL abort_validframe: seen %0b now %0b, required 1 then 0",
                      vf_seen, o_rx_valid_frame);
    end
    clear_counts();
    send_flag();
    send_byte(8'h55, 1'b1);
    send_flag();
    idle(1);
    total++;
    if (n_eof !== 1 || n_abort !== 0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL abort_recover: eof %0d abort %0d left %0d, required 1 0 0",
                      n_eof, n_abort, exp_q.size());
    end
  endtask

  task automatic test_misaligned();
    logic [3:0] tail;
    clear_counts();
    tail = 4'b0011;
    send_flag();
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_data_bit(tail[i]);
    send_flag();
    idle(1);
    total++;
    if (n_err !== 1 || n_eof !== 0) begin
      bad++; $display("FAIL misalign: err %0d eof %0d, required 1 and 0", n_err, n_eof);
    end
    total++;
    if (n_valid !== 1) begin bad++; $display("FAIL misalign_valid: got %0d, required 1", n_valid); end
  endtask

  task automatic test_overflow();
    clear_counts();
    send_flag();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), i <= MAXB);
    send_flag();
    idle(1);
    total++;
    if (n_valid !== MAXB || n_err !== 1 || n_eof !== 0) begin
      bad++; $display("FAIL overflow: valid %0d err %0d eof %0d, required %0d 1 0",
                      n_valid, n_err, n_eof, MAXB);
    end
    total++;
    if (o_rx_byte_count !== 8'(MAXB)) begin
      bad++; $display("FAIL overflow_count: got %0d, required %0d", o_rx_byte_count, MAXB);
    end
    // The closing flag already opened a new frame.
    clear_counts();
    send_byte(8'h66, 1'b1);
    send_flag();
    idle(1);
    total++;
    if (n_eof !== 1 || n_err !== 0 || o_rx_byte_count !== 8'd1) begin
      bad++; $display("FAIL overflow_restart: eof %0d err %0d count %0d, required 1 0 1",
                      n_eof, n_err, o_rx_byte_count);
    end
  endtask

  task automatic test_gating();
    clear_counts();
    gate_mode = 1'b1;
    send_flag();
    send_byte(8'hC3, 1'b1);
    send_flag();
    gate_mode = 1'b0;
    idle(1);
    total++;
    if (n_eof !== 1 || n_valid !== 1 || n_flag !== 2) begin
      bad++; $display("FAIL gating: eof %0d valid %0d flags %0d, required 1 1 2",
                      n_eof, n_valid, n_flag);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] extra;
    clear_counts();
    extra = 9'b101101001;
    send_flag();
    send_byte(8'h5A, 1'b1);
    for (int i = 0; i < 9; i++) send_data_bit(extra[i]);
    total++;
    if (o_rx_valid_frame !== 1'b1 || o_rx_byte_count !== 8'd1) begin
      bad++; $display("FAIL rstmid_pre: vf %0b count %0d, required 1 and 1",
                      o_rx_valid_frame, o_rx_byte_count);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o_rx_valid_frame !== 1'b0 || o_rx_byte_count !== 8'd0 || o_rx_data !== 8'd0) begin
      bad++; $display("FAIL rstmid_async: vf %0b count %0d data %02h, required 0 0 00",
                      o_rx_valid_frame, o_rx_byte_count, o_rx_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_ones = 0;
    clear_counts();
    send_byte(8'h99, 1'b0);
    send_byte(8'h33, 1'b0);
    idle(1);
    total++;
    if (n_valid !== 0 || vf_seen !== 1'b0 || n_flag !== 0) begin
      bad++; $display("FAIL rstmid_ignore: valid %0d vf %0b flags %0d, required 0 0 0",
                      n_valid, vf_seen, n_flag);
    end
    send_flag();
    send_byte(8'h77, 1'b1);
    send_flag();
    idle(1);
    total++;
    if (n_eof !== 1 || exp_q.size() !== 0) begin
      bad++; $display("FAIL rstmid_recover: eof %0d left %0d, required 1 and 0", n_eof, exp_q.size());
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_good_frame();
    test_latency();
    test_zero_deletion();
    test_abort();
    test_misaligned();
    test_overflow();
    test_gating();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
